// File: rtl/sprite_ram_writer_pkg.sv
// Shared constants and types for the sprite RAM writer: table geometry,
// byte lanes, the off-screen clear word and the controller state encoding.
package sprite_ram_writer_pkg;

    localparam int SPRITE_NUM_MAX = 64;
    localparam int AW             = $clog2(SPRITE_NUM_MAX);
    localparam int BYTE           = 8;
    localparam int WORD_W         = 32;
    localparam int NUM_LANES      = WORD_W / BYTE;

    // Sprite Y lives in [23:16]; 0xF0 parks the sprite below the visible area.
    localparam logic [BYTE-1:0]   Y_OFFSCREEN = 8'hF0;
    localparam logic [WORD_W-1:0] CLEAR_WORD  = {8'h00, Y_OFFSCREEN, 16'h0000};

    // Copy counter value on the cycle that performs the final active write.
    localparam logic [AW:0] COPY_LAST_CNT = (AW+1)'(SPRITE_NUM_MAX);
    localparam logic [AW-1:0] LAST_IDX    = AW'(SPRITE_NUM_MAX - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_COPY  = 2'd2
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [AW-1:0]        addr;
        logic [NUM_LANES-1:0] strb;
        logic [WORD_W-1:0]    data;
    } wr_req_t;

endpackage

// File: rtl/sprite_ram_dp.sv
// 64x32 sprite RAM with byte-lane write enables and one registered,
// read-first read port. Used for both the shadow and the active table.
module sprite_ram_dp
    import sprite_ram_writer_pkg::*;
(
    input  logic              clkEightRam,
    input  logic              rstn,
    input  wr_req_t           wr,
    input  logic [AW-1:0]     rdAddr,
    output logic [WORD_W-1:0] rdData
);

    logic [WORD_W-1:0] mem [SPRITE_NUM_MAX];

    // Merge only the enabled byte lanes into the addressed word.
    always_ff @(posedge clkEightRam) begin
        if (wr.we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr.strb[i]) mem[wr.addr][i*BYTE +: BYTE] <= wr.data[i*BYTE +: BYTE];
            end
        end
    end

    // Registered read; a same-cycle write to this address returns the old word.
    always_ff @(posedge clkEightRam) begin
        if (!rstn) rdData <= '0;
        else       rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/sprite_ram_writer.sv
// Shadow/active sprite table controller. Clears both tables after reset,
// accepts CPU byte writes into the shadow table, and on the first vertical
// blank after a commit copies shadow to active in one uninterrupted burst.
module sprite_ram_writer
    import sprite_ram_writer_pkg::*;
(
    input  logic                 clkEightRam,
    input  logic                 rstn,
    input  logic                 cpuWrEn,
    input  logic [AW-1:0]        cpuWrAddr,
    input  logic [WORD_W-1:0]    cpuWrData,
    input  logic [NUM_LANES-1:0] cpuWrStrb,
    output logic                 cpuReady,
    input  logic                 cpuCommit,
    output logic                 commitPending,
    output logic                 copyBusy,
    output logic                 frameDone,
    input  logic                 frameBlank,
    input  logic [AW-1:0]        addrReadEightRam,
    output logic [WORD_W-1:0]    dataToEightRam
);

    state_t            state;
    logic [AW:0]       cnt;          // clear index, or copy read index (0..64)
    logic [2:0]        blank_pipe;   // [1:0] synchroniser, [2] edge reference
    logic              start_pulse;
    logic              commit_req;
    wr_req_t           shWr;
    wr_req_t           acWr;
    logic [WORD_W-1:0] shRdData;

    // A commit arriving with the start pulse is folded into that copy.
    assign commit_req = commitPending | cpuCommit;

    // Two-flop sync of frameBlank, then a registered rising-edge pulse.
    always_ff @(posedge clkEightRam) begin
        if (!rstn) begin
            blank_pipe  <= '0;
            start_pulse <= 1'b0;
        end else begin
            blank_pipe  <= {blank_pipe[1:0], frameBlank};
            start_pulse <= blank_pipe[1] & ~blank_pipe[2];
        end
    end

    // Write-port steering: clear fills both tables, CPU owns shadow in IDLE,
    // the copy writes active one cycle behind its shadow read.
    always_comb begin
        shWr = '0;
        acWr = '0;
        case (state)
            ST_CLEAR: begin
                shWr.we   = 1'b1;
                shWr.addr = cnt[AW-1:0];
                shWr.strb = '1;
                shWr.data = CLEAR_WORD;
                acWr      = shWr;
            end
            ST_IDLE: begin
                shWr.we   = cpuWrEn;
                shWr.addr = cpuWrAddr;
                shWr.strb = cpuWrStrb;
                shWr.data = cpuWrData;
            end
            ST_COPY: begin
                acWr.we   = (cnt != '0);
                acWr.addr = cnt[AW-1:0] - AW'(1);
                acWr.strb = '1;
                acWr.data = shRdData;
            end
            default: ;
        endcase
    end

    // Controller FSM with registered handshake and status outputs.
    always_ff @(posedge clkEightRam) begin
        if (!rstn) begin
            state         <= ST_CLEAR;
            cnt           <= '0;
            cpuReady      <= 1'b0;
            copyBusy      <= 1'b1;
            commitPending <= 1'b0;
            frameDone     <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    commitPending <= 1'b0;
                    if (cnt[AW-1:0] == LAST_IDX) begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        cpuReady <= 1'b1;
                        copyBusy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (start_pulse && commit_req) begin
                        state         <= ST_COPY;
                        cnt           <= '0;
                        cpuReady      <= 1'b0;
                        copyBusy      <= 1'b1;
                        commitPending <= 1'b0;
                    end else begin
                        commitPending <= commit_req;
                    end
                end
                ST_COPY: begin
                    commitPending <= commit_req;
                    if (cnt == COPY_LAST_CNT) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        cpuReady  <= 1'b1;
                        copyBusy  <= 1'b0;
                        frameDone <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_CLEAR;
                    cnt      <= '0;
                    cpuReady <= 1'b0;
                    copyBusy <= 1'b1;
                end
            endcase
        end
    end

    sprite_ram_dp u_shadow (
        .clkEightRam (clkEightRam),
        .rstn        (rstn),
        .wr          (shWr),
        .rdAddr      (cnt[AW-1:0]),
        .rdData      (shRdData)
    );

    sprite_ram_dp u_active (
        .clkEightRam (clkEightRam),
        .rstn        (rstn),
        .wr          (acWr),
        .rdAddr      (addrReadEightRam),
        .rdData      (dataToEightRam)
    );

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Directed-plus-random bench for sprite_ram_writer. Keeps shadow/active
// tables as plain arrays and compares every active entry after each copy.
module tb_sprite_ram_writer;

    localparam logic [31:0] CLR     = 32'h00F0_0000;
    localparam int          CLR_LEN = 64;   // cycles until cpuReady after reset
    localparam int          BUSY_AT = 4;    // 3-cycle edge detect, then entry
    localparam int          DONE_AT = 69;   // entry cycle + 65 more

    logic        clkEightRam = 1'b0;
    logic        rstn        = 1'b0;
    logic        cpuWrEn     = 1'b0;
    logic [5:0]  cpuWrAddr   = '0;
    logic [31:0] cpuWrData   = '0;
    logic [3:0]  cpuWrStrb   = '0;
    logic        cpuReady;
    logic        cpuCommit   = 1'b0;
    logic        commitPending;
    logic        copyBusy;
    logic        frameDone;
    logic        frameBlank  = 1'b0;
    logic [5:0]  addrReadEightRam = '0;
    logic [31:0] dataToEightRam;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] shadow_m [64];
    logic [31:0] active_m [64];

    always #5 clkEightRam = ~clkEightRam;

    sprite_ram_writer dut (
        .clkEightRam      (clkEightRam),
        .rstn             (rstn),
        .cpuWrEn          (cpuWrEn),
        .cpuWrAddr        (cpuWrAddr),
        .cpuWrData        (cpuWrData),
        .cpuWrStrb        (cpuWrStrb),
        .cpuReady         (cpuReady),
        .cpuCommit        (cpuCommit),
        .commitPending    (commitPending),
        .copyBusy         (copyBusy),
        .frameDone        (frameDone),
        .frameBlank       (frameBlank),
        .addrReadEightRam (addrReadEightRam),
        .dataToEightRam   (dataToEightRam)
    );

    task automatic tick();
        @(posedge clkEightRam);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            shadow_m[i] = CLR;
            active_m[i] = CLR;
        end
    endtask

    // Count cycles from rstn release to cpuReady; optionally poke a commit
    // mid-clear, which must be dropped.
    task automatic wait_ready(input bit commit_mid);
        int  k    = 0;
        bit  busy = 1'b1;
        rstn = 1'b1;
        while (!cpuReady && k < 200) begin
            tick();
            k++;
            if (!cpuReady && !copyBusy) busy = 1'b0;
            cpuCommit = commit_mid && (k == 10);
        end
        cpuCommit = 1'b0;
        chk("clear_len", k, CLR_LEN);
        chk("clear_busy", busy, 1'b1);
        chk("clear_busy_drop", copyBusy, 1'b0);
        chk("clear_no_pending", commitPending, 1'b0);
    endtask

    task automatic check_active_all(input string tag);
        for (int i = 0; i < 64; i++) begin
            addrReadEightRam = 6'(i);
            tick();
            chk($sformatf("%s[%0d]", tag, i), dataToEightRam, active_m[i]);
        end
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit with_commit);
        int n = 0;
        cpuWrEn = 1'b1; cpuWrAddr = a; cpuWrData = d; cpuWrStrb = s;
        while (!cpuReady && n < 200) begin tick(); n++; end
        chk("wr_ready", cpuReady, 1'b1);
        cpuCommit = with_commit;
        tick();
        cpuWrEn = 1'b0; cpuCommit = 1'b0;
        shadow_m[a] = merge(shadow_m[a], d, s);
        if (with_commit) chk("wr_commit_pending", commitPending, 1'b1);
    endtask

    task automatic commit();
        cpuCommit = 1'b1;
        tick();
        cpuCommit = 1'b0;
        chk("commit_pending", commitPending, 1'b1);
    endtask

    // Raise blank and follow one copy; optional commit and held write mid-copy.
    task automatic run_blank(input bit mid_commit, input bit mid_write,
                             input logic [5:0] wa, input logic [31:0] wd, input logic [3:0] ws);
        int busy_at = -1;
        int done_at = -1;
        frameBlank = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (busy_at < 0 && copyBusy) busy_at = k;
            if (frameDone) begin done_at = k; break; end
            cpuCommit = mid_commit && (k == 14);
            if (mid_write && k == 20) begin
                cpuWrEn = 1'b1; cpuWrAddr = wa; cpuWrData = wd; cpuWrStrb = ws;
            end
            if (mid_write && k == 40) chk("copy_stall_ready", cpuReady, 1'b0);
            if (k == 30) frameBlank = 1'b0;
        end
        frameBlank = 1'b0;
        cpuCommit  = 1'b0;
        chk("copy_start", busy_at, BUSY_AT);
        chk("copy_done", done_at, DONE_AT);
        chk("copy_idle_ready", cpuReady, 1'b1);
        for (int i = 0; i < 64; i++) active_m[i] = shadow_m[i];
        tick();
        if (mid_write) begin
            cpuWrEn = 1'b0;
            shadow_m[wa] = merge(shadow_m[wa], wd, ws);
        end
        chk("done_pulse", frameDone, 1'b0);
        chk("done_busy", copyBusy, 1'b0);
        chk("done_pending", commitPending, mid_commit);
    endtask

    initial begin
        logic [5:0]  ha;
        logic [31:0] hd;
        logic [3:0]  hs;
        bit          any_busy;
        int          n;

        model_reset();
        repeat (3) tick();
        chk("rst_ready", cpuReady, 1'b0);
        chk("rst_busy", copyBusy, 1'b1);
        chk("rst_pending", commitPending, 1'b0);
        chk("rst_done", frameDone, 1'b0);
        chk("rst_data", dataToEightRam, 32'h0);

        wait_ready(1'b1);
        check_active_all("clear");

        // Single-lane write over the clear word: only the Y byte lands.
        cpu_write(6'd5, 32'h1122_3344, 4'b0100, 1'b0);
        commit();
        run_blank(1'b0, 1'b0, '0, '0, '0);
        check_active_all("y_merge");
        addrReadEightRam = 6'd5;
        tick();
        chk("y_merge_const", dataToEightRam, 32'h0022_0000);

        // One-cycle read latency: changing the address shows the old word.
        addrReadEightRam = 6'd6;
        #1;
        chk("read_latency", dataToEightRam, 32'h0022_0000);

        // Blank with nothing pending must not start a copy.
        any_busy   = 1'b0;
        frameBlank = 1'b1;
        repeat (10) begin tick(); if (copyBusy) any_busy = 1'b1; end
        frameBlank = 1'b0;
        repeat (4) tick();
        chk("no_pending_no_copy", any_busy, 1'b0);

        // Random writes, a commit, more writes, then write+commit together.
        repeat (30) cpu_write(6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)), 1'b0);
        commit();
        repeat (8) cpu_write(6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)), 1'b0);
        cpu_write(6'd63, 32'hDEAD_BEEF, 4'hF, 1'b1);
        repeat (5) tick();
        ha = 6'($urandom_range(0, 63));
        hd = $urandom;
        hs = 4'($urandom_range(1, 15));
        run_blank(1'b1, 1'b1, ha, hd, hs);
        check_active_all("rand_copy");

        // Writes between the two commits ride on the pending second copy.
        repeat (10) cpu_write(6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)), 1'b0);
        run_blank(1'b0, 1'b0, '0, '0, '0);
        check_active_all("second_copy");

        // Reset in the middle of a copy: both tables return to the clear word.
        cpu_write(6'd7, 32'h5555_AAAA, 4'hF, 1'b1);
        frameBlank = 1'b1;
        n = 0;
        while (!copyBusy && n < 20) begin tick(); n++; end
        chk("abort_copy_started", copyBusy, 1'b1);
        repeat (29) tick();
        rstn = 1'b0;
        tick();
        frameBlank = 1'b0;
        chk("abort_busy", copyBusy, 1'b1);
        chk("abort_ready", cpuReady, 1'b0);
        chk("abort_pending", commitPending, 1'b0);
        model_reset();
        wait_ready(1'b0);
        check_active_all("abort_clear");

        // Copying the untouched shadow shows it was cleared as well.
        commit();
        run_blank(1'b0, 1'b0, '0, '0, '0);
        check_active_all("shadow_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
